// File: rtl/ladybird_bus_arbiter.sv
// ladybird_bus_arbiter
//   Shares one external memory port between the instruction-fetch (i_*) and
//   data/MMU (d_*) requesters. One transaction is outstanding at a time.
//   When both paths request at once, the grant alternates (round-robin).
//   A response timeout in WAIT stops a dead slave from hanging the core.
//
// Ports
//   clk, anrst (async, active-low), nrst (sync, active-low)
//   i_/d_  req, addr, wdata, wstrb  : requests, held until *_ready
//   i_/d_  ready                    : combinational accept
//   i_/d_  rvalid, rdata, err       : registered completion pulse (err = timeout)
//   m_req, m_addr, m_wdata, m_wstrb : registered memory request
//   m_ready, m_rvalid, m_rdata      : memory handshake and response
//
// state  | meaning
// IDLE   | no transaction; arbitrate and accept a request
// ISSUE  | m_req held until m_ready
// WAIT   | waiting for m_rvalid or for the timeout counter to expire
module ladybird_bus_arbiter #(
    parameter int XLEN    = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              anrst,
    input  logic              nrst,
    input  logic              i_req,
    input  logic [XLEN-1:0]   i_addr,
    input  logic [XLEN-1:0]   i_wdata,
    input  logic [XLEN/8-1:0] i_wstrb,
    output logic              i_ready,
    output logic              i_rvalid,
    input  logic              d_req,
    input  logic [XLEN-1:0]   d_addr,
    input  logic [XLEN-1:0]   d_wdata,
    input  logic [XLEN/8-1:0] d_wstrb,
    output logic              d_ready,
    output logic              d_rvalid,
    output logic [XLEN-1:0]   rdata,
    output logic              err,
    output logic              m_req,
    output logic [XLEN-1:0]   m_addr,
    output logic [XLEN-1:0]   m_wdata,
    output logic [XLEN/8-1:0] m_wstrb,
    input  logic              m_ready,
    input  logic              m_rvalid,
    input  logic [XLEN-1:0]   m_rdata
);

    // A disabled timeout still needs a 1-bit counter to keep widths legal.
    localparam int            CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
    localparam bit            TMO_EN = (TIMEOUT > 0);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } state_t;

    state_t              state_q,   state_d;
    logic                owner_q,   owner_d;    // 1 = data path owns the bus
    logic                last_q,    last_d;     // 1 = data path was granted last
    logic [CW-1:0]       cnt_q,     cnt_d;
    logic                m_req_q,   m_req_d;
    logic [XLEN-1:0]     m_addr_q,  m_addr_d;
    logic [XLEN-1:0]     m_wdata_q, m_wdata_d;
    logic [XLEN/8-1:0]   m_wstrb_q, m_wstrb_d;
    logic                i_rvalid_q, i_rvalid_d;
    logic                d_rvalid_q, d_rvalid_d;
    logic [XLEN-1:0]     rdata_q,   rdata_d;
    logic                err_q,     err_d;

    logic grant_i, grant_d, is_idle, timed_out;

    // Instruction wins contention only if data had the previous grant.
    assign grant_i   = i_req & (~d_req | last_q);
    assign grant_d   = d_req & ~grant_i;
    assign is_idle   = (state_q == ST_IDLE);
    assign timed_out = TMO_EN && (cnt_q == TMO);

    // Ready is gated by both resets so no request is consumed while the
    // arbiter is being cleared.
    assign i_ready = anrst & nrst & is_idle & grant_i;
    assign d_ready = anrst & nrst & is_idle & grant_d;

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        m_req_d    = m_req_q;
        m_addr_d   = m_addr_q;
        m_wdata_d  = m_wdata_q;
        m_wstrb_d  = m_wstrb_q;
        i_rvalid_d = 1'b0;
        d_rvalid_d = 1'b0;
        rdata_d    = rdata_q;
        err_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (grant_i || grant_d) begin
                    owner_d   = grant_d;
                    last_d    = grant_d;
                    m_addr_d  = grant_d ? d_addr  : i_addr;
                    m_wdata_d = grant_d ? d_wdata : i_wdata;
                    m_wstrb_d = grant_d ? d_wstrb : i_wstrb;
                    m_req_d   = 1'b1;
                    state_d   = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (m_ready) begin
                    m_req_d = 1'b0;
                    cnt_d   = '0;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A real response beats a simultaneous timeout.
                if (m_rvalid) begin
                    i_rvalid_d = ~owner_q;
                    d_rvalid_d = owner_q;
                    rdata_d    = m_rdata;
                    state_d    = ST_IDLE;
                end else if (timed_out) begin
                    i_rvalid_d = ~owner_q;
                    d_rvalid_d = owner_q;
                    rdata_d    = '0;
                    err_d      = 1'b1;
                    state_d    = ST_IDLE;
                end else if (cnt_q != '1) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (!nrst) begin
            state_d    = ST_IDLE;
            owner_d    = 1'b0;
            last_d     = 1'b1;
            cnt_d      = '0;
            m_req_d    = 1'b0;
            m_addr_d   = '0;
            m_wdata_d  = '0;
            m_wstrb_d  = '0;
            i_rvalid_d = 1'b0;
            d_rvalid_d = 1'b0;
            rdata_d    = '0;
            err_d      = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge anrst) begin
        if (!anrst) begin
            state_q    <= ST_IDLE;
            owner_q    <= 1'b0;
            last_q     <= 1'b1;
            cnt_q      <= '0;
            m_req_q    <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            m_wstrb_q  <= '0;
            i_rvalid_q <= 1'b0;
            d_rvalid_q <= 1'b0;
            rdata_q    <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            m_req_q    <= m_req_d;
            m_addr_q   <= m_addr_d;
            m_wdata_q  <= m_wdata_d;
            m_wstrb_q  <= m_wstrb_d;
            i_rvalid_q <= i_rvalid_d;
            d_rvalid_q <= d_rvalid_d;
            rdata_q    <= rdata_d;
            err_q      <= err_d;
        end
    end

    assign m_req    = m_req_q;
    assign m_addr   = m_addr_q;
    assign m_wdata  = m_wdata_q;
    assign m_wstrb  = m_wstrb_q;
    assign i_rvalid = i_rvalid_q;
    assign d_rvalid = d_rvalid_q;
    assign rdata    = rdata_q;
    assign err      = err_q;

endmodule

// File: tb/tb_ladybird_bus_arbiter.sv
// tb_ladybird_bus_arbiter
//   Directed bench for ladybird_bus_arbiter built with TIMEOUT = 4.
//   Inputs change 1 ns after the rising edge; outputs are sampled 1-2 ns
//   after the edge, well away from it.
module tb_ladybird_bus_arbiter;

    logic        clk = 1'b0;
    logic        anrst, nrst;
    logic        i_req, d_req;
    logic [31:0] i_addr, i_wdata, d_addr, d_wdata;
    logic [3:0]  i_wstrb, d_wstrb;
    logic        i_ready, d_ready, i_rvalid, d_rvalid, err;
    logic [31:0] rdata;
    logic        m_req, m_ready, m_rvalid;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic [3:0]  m_wstrb;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    ladybird_bus_arbiter #(.XLEN(32), .TIMEOUT(4)) dut (
        .clk      (clk),
        .anrst    (anrst),
        .nrst     (nrst),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_wdata  (i_wdata),
        .i_wstrb  (i_wstrb),
        .i_ready  (i_ready),
        .i_rvalid (i_rvalid),
        .d_req    (d_req),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_wstrb  (d_wstrb),
        .d_ready  (d_ready),
        .d_rvalid (d_rvalid),
        .rdata    (rdata),
        .err      (err),
        .m_req    (m_req),
        .m_addr   (m_addr),
        .m_wdata  (m_wdata),
        .m_wstrb  (m_wstrb),
        .m_ready  (m_ready),
        .m_rvalid (m_rvalid),
        .m_rdata  (m_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full read through one requester with an immediately responsive memory.
    // Starts in an IDLE cycle; ends in the completion cycle (state IDLE).
    task automatic run_txn(input bit use_d, input logic [31:0] addr, input logic [31:0] dat);
        i_req = !use_d; d_req = use_d;
        i_addr = addr;  d_addr = addr;
        i_wstrb = 4'h0; d_wstrb = 4'h0;
        m_ready = 1'b1;
        #1;
        check("txn_ready", 32'(use_d ? d_ready : i_ready), 32'd1);
        check("txn_other_ready", 32'(use_d ? i_ready : d_ready), 32'd0);
        tick;
        i_req = 1'b0; d_req = 1'b0;
        check("txn_m_req_rise", 32'(m_req), 32'd1);
        check("txn_m_addr", m_addr, addr);
        tick;
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = dat;
        check("txn_m_req_drop", 32'(m_req), 32'd0);
        check("txn_no_early_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        tick;
        m_rvalid = 1'b0;
        check("txn_rvalid", 32'({i_rvalid, d_rvalid}), use_d ? 32'd1 : 32'd2);
        check("txn_rdata", rdata, dat);
        check("txn_err", 32'(err), 32'd0);
    endtask

    initial begin
        anrst = 1'b0; nrst = 1'b1;
        i_req = 1'b1; d_req = 1'b0;
        i_addr = '0; i_wdata = '0; i_wstrb = '0;
        d_addr = '0; d_wdata = '0; d_wstrb = '0;
        m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;

        // ---- reset values, ready suppressed while anrst low
        #2;
        check("rst_i_ready", 32'(i_ready), 32'd0);
        check("rst_m_req", 32'(m_req), 32'd0);
        check("rst_m_addr", m_addr, 32'd0);
        check("rst_m_wdata", m_wdata, 32'd0);
        check("rst_m_wstrb", 32'(m_wstrb), 32'd0);
        check("rst_rvalid", 32'({i_rvalid, d_rvalid}), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_err", 32'(err), 32'd0);
        i_req = 1'b0;
        #10 anrst = 1'b1;
        tick;

        // ---- single read on the data path
        run_txn(1'b1, 32'h0000_0100, 32'hDEAD_BEEF);
        tick;
        check("single_rvalid_pulse", 32'({i_rvalid, d_rvalid}), 32'd0);

        // ---- contention: both held from reset, grants alternate I, D, I, D
        nrst = 1'b0;
        tick;
        nrst = 1'b1;
        i_req = 1'b1; d_req = 1'b1;
        i_addr = 32'h200; d_addr = 32'h300;
        m_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            check("cont_i_ready", 32'(i_ready), (k % 2 == 0) ? 32'd1 : 32'd0);
            check("cont_d_ready", 32'(d_ready), (k % 2 == 0) ? 32'd0 : 32'd1);
            tick;
            check("cont_m_addr", m_addr, (k % 2 == 0) ? 32'h200 : 32'h300);
            check("cont_busy_ready", 32'({i_ready, d_ready}), 32'd0);
            tick;
            m_rvalid = 1'b1; m_rdata = 32'(k + 16);
            tick;
            m_rvalid = 1'b0;
            check("cont_rvalid", 32'({i_rvalid, d_rvalid}), (k % 2 == 0) ? 32'd2 : 32'd1);
            check("cont_rdata", rdata, 32'(k + 16));
        end
        i_req = 1'b0; d_req = 1'b0;
        m_ready = 1'b0;

        // ---- write with a 5-cycle m_ready stall; data request arrives meanwhile
        i_req = 1'b1; i_addr = 32'h440; i_wdata = 32'h1234_5678; i_wstrb = 4'b0001;
        #1;
        check("ws_i_ready", 32'(i_ready), 32'd1);
        tick;
        i_req = 1'b0; i_addr = 32'hFFFF_FFF0; i_wdata = 32'h0; i_wstrb = 4'h0;
        d_req = 1'b1; d_addr = 32'h500; d_wstrb = 4'h0;
        for (int c = 0; c < 5; c++) begin
            #1;
            check("ws_m_req", 32'(m_req), 32'd1);
            check("ws_m_addr", m_addr, 32'h440);
            check("ws_m_wdata", m_wdata, 32'h1234_5678);
            check("ws_m_wstrb", 32'(m_wstrb), 32'd1);
            check("ws_d_pending", 32'(d_ready), 32'd0);
            tick;
        end
        m_ready = 1'b1;
        check("ws_m_req_last", 32'(m_req), 32'd1);
        tick;
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'h77;
        #1;
        check("ws_d_wait", 32'(d_ready), 32'd0);
        tick;
        m_rvalid = 1'b0;
        #1;
        check("ws_i_rvalid", 32'({i_rvalid, d_rvalid}), 32'd2);
        check("ws_err", 32'(err), 32'd0);
        check("ws_d_granted", 32'(d_ready), 32'd1);

        // ---- timeout: pending data read, memory never responds
        tick;
        d_req = 1'b0; m_ready = 1'b1;
        check("to_m_addr", m_addr, 32'h500);
        tick;
        m_ready = 1'b0;
        for (int c = 0; c < 5; c++) begin
            check("to_wait_quiet", 32'({i_rvalid, d_rvalid, err}), 32'd0);
            tick;
        end
        check("to_d_rvalid", 32'({i_rvalid, d_rvalid}), 32'd1);
        check("to_err", 32'(err), 32'd1);
        check("to_rdata", rdata, 32'd0);
        m_rvalid = 1'b1; m_rdata = 32'h1111;
        tick;
        m_rvalid = 1'b0;
        check("stray_rvalid", 32'({i_rvalid, d_rvalid, err}), 32'd0);
        check("stray_m_req", 32'(m_req), 32'd0);

        // ---- synchronous reset mid-WAIT, with a response in the same cycle
        i_req = 1'b1; i_addr = 32'h600; i_wstrb = 4'h0;
        #1;
        check("nr_i_ready", 32'(i_ready), 32'd1);
        tick;
        i_req = 1'b0; m_ready = 1'b1;
        tick;
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFE; nrst = 1'b0;
        tick;
        m_rvalid = 1'b0; nrst = 1'b1;
        check("nr_no_rvalid", 32'({i_rvalid, d_rvalid, err}), 32'd0);
        check("nr_m_req", 32'(m_req), 32'd0);
        // last was instruction before the reset; reset makes instruction win again
        i_req = 1'b1; d_req = 1'b1; i_addr = 32'h610; d_addr = 32'h710;
        #1;
        check("nr_rr_reset", 32'({i_ready, d_ready}), 32'd2);
        tick;
        i_req = 1'b0; d_req = 1'b0; m_ready = 1'b1;
        check("nr_m_addr", m_addr, 32'h610);
        tick;
        m_ready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hA5A5;
        tick;
        m_rvalid = 1'b0;
        check("nr_rvalid", 32'({i_rvalid, d_rvalid}), 32'd2);
        check("nr_rdata", rdata, 32'hA5A5);

        // ---- asynchronous reset mid-WAIT
        i_req = 1'b1; i_addr = 32'h800;
        #1;
        tick;
        i_req = 1'b0; m_ready = 1'b1;
        tick;
        m_ready = 1'b0;
        #2;
        anrst = 1'b0; m_rvalid = 1'b1; i_req = 1'b1;
        #1;
        check("ar_i_ready", 32'(i_ready), 32'd0);
        check("ar_m_req", 32'(m_req), 32'd0);
        tick;
        m_rvalid = 1'b0; i_req = 1'b0;
        check("ar_no_rvalid", 32'({i_rvalid, d_rvalid, err}), 32'd0);
        #2 anrst = 1'b1;
        tick;
        check("ar_idle_quiet", 32'({i_rvalid, d_rvalid, m_req}), 32'd0);
        run_txn(1'b1, 32'h0000_0900, 32'h0BAD_F00D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ladybird_bus_arbiter.md
# ladybird_bus_arbiter

Two-requester, single-outstanding memory bus arbiter that shares one external memory port between the ladybird core's instruction-fetch path and its data (MMU) path. Each requester presents a request/accept handshake and receives a completion pulse with read data. Transactions are issued strictly one at a time, granted round-robin, and a bounded response timeout prevents a dead slave from hanging the core.

## Interface
- XLEN, 32, address/data width
- TIMEOUT, 255, maximum cycles waited in WAIT for m_rvalid; 0 disables the timeout
- clk  in  1  clock
- anrst  in  1  reset, asynchronous, active-low
- nrst  in  1  synchronous reset, active-low; same effect as anrst
- i_req, d_req  in  1  request; held with its payload until the matching *_ready
- i_addr, d_addr  in  XLEN  byte address
- i_wdata, d_wdata  in  XLEN  write data
- i_wstrb, d_wstrb  in  XLEN/8  byte write strobes; all-zero means read
- i_ready, d_ready  out  1  request accepted this cycle (combinational)
- i_rvalid, d_rvalid  out  1  one-cycle completion pulse to the owner
- rdata  out  XLEN  read data, valid with either *_rvalid
- err  out  1  pulses with *_rvalid when the completion was caused by timeout
- m_req  out  1  memory request, registered, held until m_ready
- m_addr, m_wdata, m_wstrb  out  XLEN, XLEN, XLEN/8  latched payload, stable while m_req
- m_ready  in  1  memory accepts request
- m_rvalid  in  1  memory completion (reads and writes)
- m_rdata  in  XLEN  memory read data

## Operation
- States: IDLE, ISSUE, WAIT. Reset state IDLE.
- IDLE: winner = only requester, or, when both request, the one not in `last` (round-robin). Winner's *_ready = 1; loser's *_ready = 0. On accept: latch addr/wdata/wstrb into m_*, record owner, set last = owner, go ISSUE.
- ISSUE: m_req = 1; on m_req & m_ready, go WAIT and clear timeout counter.
- WAIT: on m_rvalid: next cycle, owner's *_rvalid = 1, rdata = m_rdata (registered), err = 0, go IDLE.
- WAIT timeout: the counter increments every WAIT cycle without m_rvalid. When it reaches TIMEOUT, the next cycle pulses owner's *_rvalid with rdata = 0 and err = 1, then goes IDLE.
- Counter width is $clog2(TIMEOUT+1). It saturates and never wraps.
- m_rvalid arriving in IDLE or ISSUE (late or stray response) is ignored.
- m_rvalid and timeout expiry in the same cycle: m_rvalid wins, err = 0.
- *_ready is never asserted outside IDLE. Requests arriving in ISSUE/WAIT stay pending with no loss.
- Reset value of `last` is data, so instruction wins the first contention.
- Reset (anrst or nrst) mid-transaction: abort with no *_rvalid; m_req drops; state IDLE.
- m_addr/m_wdata/m_wstrb hold their last value outside ISSUE.

## Timing
- Reset values: m_req 0, m_addr 0, m_wdata 0, m_wstrb 0, i_rvalid 0, d_rvalid 0, rdata 0, err 0. i_ready/d_ready are 0 while anrst is low.
- Accept at cycle T: m_req rises T+1.
- m_ready at T+1 and m_rvalid at T+2: *_rvalid at T+3, and the state is IDLE at T+3, so a new accept is possible at T+3.
- Minimum request-to-completion is 3 cycles. Back-to-back throughput is one transaction per 3 cycles.
- m_ready low stalls in ISSUE indefinitely; there is no timeout in ISSUE.
- *_rvalid, rdata and err are registered; i_rvalid and d_rvalid are never high together.

## Test plan
- Single read: d_req, d_addr=0x100, wstrb=0; memory m_ready at once, m_rdata=0xDEADBEEF after 1 cycle -> d_ready at T, m_req at T+1, d_rvalid with rdata=0xDEADBEEF at T+3, err=0.
- Contention: i_req and d_req held together from reset -> order of grants is I, D, I, D; each m_addr matches its owner; no dropped request.
- Write stall: i_wstrb=4'b0001, m_ready low 5 cycles -> m_req held, m_addr/m_wdata/m_wstrb stable throughout, then one i_rvalid after m_rvalid.
- Timeout with TIMEOUT=4: m_rvalid never comes -> d_rvalid with err=1 and rdata=0 exactly 5 cycles after entering WAIT. A stray m_rvalid afterward produces no output.
- Reset mid-WAIT: nrst low one cycle -> no *_rvalid, m_req 0, next request serviced normally starting from IDLE. Repeat with anrst asserted asynchronously.
